// File: rtl/axi_lite_slave_ctrl_pkg.sv
// axi_lite_slave_ctrl_pkg: shared response codes, FSM state types and default watchdog length.
package axi_lite_pkg;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam int TIMEOUT_CYC_DEF = 256;
    typedef enum logic [1:0] {W_IDLE, W_EXEC, W_RESP} wr_state_t;
    typedef enum logic [1:0] {R_IDLE, R_EXEC, R_RESP} rd_state_t;
endpackage

// File: rtl/axi_lite_slave_ctrl_if.sv
// axi_lite_slave_ctrl_if: AXI4-Lite bus bundle between the PS GP port and the slave front-end.
interface axi_lite_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   awaddr;
    logic                awvalid;
    logic                awready;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wvalid;
    logic                wready;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;
    logic [ADDR_W-1:0]   araddr;
    logic                arvalid;
    logic                arready;
    logic [DATA_W-1:0]   rdata;
    logic [1:0]          rresp;
    logic                rvalid;
    logic                rready;
    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/axi_lite_slave_ctrl_timer.sv
// axi_txn_timer: saturating request watchdog, expired once the count reaches TIMEOUT_CYC-1.
import axi_lite_pkg::*;
module axi_txn_timer #(
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear_i,
    input  logic en_i,
    output logic expired_o
);
    localparam int W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [W-1:0] LAST = W'(TIMEOUT_CYC - 1);
    logic [W-1:0] cnt_q, cnt_d;
    assign expired_o = cnt_q == LAST;
    always_comb cnt_d = clear_i ? '0 : (en_i && !expired_o) ? cnt_q + W'(1) : cnt_q;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
endmodule

// File: rtl/axi_lite_slave_ctrl.sv
// axi_lite_slave_ctrl: AXI4-Lite slave that turns bus transactions into held we/re back-end requests,
// with a per-path watchdog that answers SLVERR when the back-end never signals done.
import axi_lite_pkg::*;
module axi_lite_slave_ctrl #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    axi_lite_if.slave         s_axi,
    output logic              we,
    output logic [ADDR_W-1:0] waddr,
    output logic [DATA_W-1:0] wdata,
    input  logic              wdone,
    output logic              re,
    output logic [ADDR_W-1:0] raddr,
    input  logic [DATA_W-1:0] rdata,
    input  logic              rdone
);
    wr_state_t           wr_q;
    rd_state_t           rd_q;
    logic                init_q, aw_held_q, w_held_q;
    logic [ADDR_W-1:0]   waddr_q, raddr_q;
    logic [DATA_W-1:0]   wdata_q, rdata_q;
    logic [DATA_W/8-1:0] wstrb_q;
    logic [1:0]          bresp_q, rresp_q;
    logic                aw_hs, w_hs, full, w_exp, r_exp;
    // init_q keeps every ready low until the first edge after reset release
    assign s_axi.awready = init_q && wr_q == W_IDLE && !aw_held_q;
    assign s_axi.wready  = init_q && wr_q == W_IDLE && !w_held_q;
    assign s_axi.arready = init_q && rd_q == R_IDLE;
    assign s_axi.bvalid  = wr_q == W_RESP;
    assign s_axi.bresp   = bresp_q;
    assign s_axi.rvalid  = rd_q == R_RESP;
    assign s_axi.rresp   = rresp_q;
    assign s_axi.rdata   = rdata_q;
    assign we    = wr_q == W_EXEC;
    assign waddr = waddr_q;
    assign wdata = wdata_q;
    assign re    = rd_q == R_EXEC;
    assign raddr = raddr_q;
    assign aw_hs = s_axi.awvalid && s_axi.awready;
    assign w_hs  = s_axi.wvalid && s_axi.wready;
    assign full  = (w_held_q ? wstrb_q : s_axi.wstrb) == '1;
    axi_txn_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_wtimer (
        .clk(clk), .rst_n(rst_n), .clear_i(wr_q != W_EXEC), .en_i(wr_q == W_EXEC), .expired_o(w_exp)
    );
    axi_txn_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_rtimer (
        .clk(clk), .rst_n(rst_n), .clear_i(rd_q != R_EXEC), .en_i(rd_q == R_EXEC), .expired_o(r_exp)
    );
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) init_q <= 1'b0;
        else        init_q <= 1'b1;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            wr_q      <= W_IDLE;
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            waddr_q   <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            bresp_q   <= RESP_OKAY;
        end else begin
            case (wr_q)
                W_IDLE: begin
                    if (aw_hs) begin
                        aw_held_q <= 1'b1;
                        waddr_q   <= s_axi.awaddr;
                    end
                    if (w_hs) begin
                        w_held_q <= 1'b1;
                        wdata_q  <= s_axi.wdata;
                        wstrb_q  <= s_axi.wstrb;
                    end
                    // partial writes skip the back-end and answer SLVERR straight away
                    if ((aw_held_q || aw_hs) && (w_held_q || w_hs)) begin
                        wr_q    <= full ? W_EXEC : W_RESP;
                        bresp_q <= full ? RESP_OKAY : RESP_SLVERR;
                    end
                end
                W_EXEC: if (wdone || w_exp) begin
                    wr_q    <= W_RESP;
                    bresp_q <= wdone ? RESP_OKAY : RESP_SLVERR;
                end
                W_RESP: if (s_axi.bready) begin
                    wr_q      <= W_IDLE;
                    aw_held_q <= 1'b0;
                    w_held_q  <= 1'b0;
                end
                default: wr_q <= W_IDLE;
            endcase
        end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            rd_q    <= R_IDLE;
            raddr_q <= '0;
            rdata_q <= '0;
            rresp_q <= RESP_OKAY;
        end else begin
            case (rd_q)
                R_IDLE: if (s_axi.arvalid && s_axi.arready) begin
                    rd_q    <= R_EXEC;
                    raddr_q <= s_axi.araddr;
                end
                R_EXEC: if (rdone || r_exp) begin
                    rd_q    <= R_RESP;
                    rdata_q <= rdone ? rdata : '0;
                    rresp_q <= rdone ? RESP_OKAY : RESP_SLVERR;
                end
                R_RESP: if (s_axi.rready) rd_q <= R_IDLE;
                default: rd_q <= R_IDLE;
            endcase
        end
endmodule

// File: tb/tb_axi_lite_slave_ctrl.sv
// tb_axi_lite_slave_ctrl: directed scenarios for the AXI4-Lite slave front-end with an 8-cycle watchdog.
module tb_axi_lite_slave_ctrl;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        we, re, wdone, rdone;
    logic [31:0] waddr, wdata, raddr, rdata;
    int          checks = 0;
    int          errors = 0;
    axi_lite_if #(.ADDR_W(32), .DATA_W(32)) bus ();
    axi_lite_slave_ctrl #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYC(8)) dut (
        .clk(clk), .rst_n(rst_n), .s_axi(bus),
        .we(we), .waddr(waddr), .wdata(wdata), .wdone(wdone),
        .re(re), .raddr(raddr), .rdata(rdata), .rdone(rdone)
    );
    always #5 clk = ~clk;

    task automatic idle_inputs();
        bus.awaddr = '0; bus.awvalid = 0; bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 0;
        bus.bready = 0; bus.araddr = '0; bus.arvalid = 0; bus.rready = 0;
        wdone = 0; rdone = 0; rdata = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        @(negedge clk);
        checks++; if ({we, re, bus.bvalid, bus.rvalid} !== 4'b0) begin errors++; $display("FAIL reset_outs: got %b exp 0000", {we, re, bus.bvalid, bus.rvalid}); end
        checks++; if ({bus.awready, bus.wready, bus.arready} !== 3'b0) begin errors++; $display("FAIL reset_ready: got %b exp 000", {bus.awready, bus.wready, bus.arready}); end
        rst_n = 1; #1;
        checks++; if ({bus.awready, bus.wready, bus.arready} !== 3'b0) begin errors++; $display("FAIL ready_before_edge: got %b exp 000", {bus.awready, bus.wready, bus.arready}); end
        @(negedge clk);
        checks++; if ({bus.awready, bus.wready, bus.arready} !== 3'b111) begin errors++; $display("FAIL ready_after_edge: got %b exp 111", {bus.awready, bus.wready, bus.arready}); end
    endtask

    task automatic test_same_cycle_write();
        bus.awaddr = 32'h10; bus.awvalid = 1; bus.wdata = 32'hDEADBEEF; bus.wstrb = 4'hF; bus.wvalid = 1;
        @(negedge clk);
        bus.awvalid = 0; bus.wvalid = 0;
        checks++; if ({we, waddr, wdata} !== {1'b1, 32'h10, 32'hDEADBEEF}) begin errors++; $display("FAIL w1_we_cyc1: got %b %h %h exp 1 10 deadbeef", we, waddr, wdata); end
        checks++; if ({bus.awready, bus.wready} !== 2'b00) begin errors++; $display("FAIL w1_ready_exec: got %b exp 00", {bus.awready, bus.wready}); end
        @(negedge clk);
        checks++; if ({we, waddr, wdata} !== {1'b1, 32'h10, 32'hDEADBEEF}) begin errors++; $display("FAIL w1_we_cyc2: got %b %h %h exp 1 10 deadbeef", we, waddr, wdata); end
        wdone = 1;
        @(negedge clk);
        wdone = 0;
        checks++; if ({we, bus.bvalid, bus.bresp} !== 4'b0100) begin errors++; $display("FAIL w1_bresp: got %b exp 0100", {we, bus.bvalid, bus.bresp}); end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++; if ({bus.bvalid, bus.bresp, bus.awready} !== 4'b1000) begin errors++; $display("FAIL w1_bhold%0d: got %b exp 1000", i, {bus.bvalid, bus.bresp, bus.awready}); end
        end
        bus.bready = 1;
        @(negedge clk);
        bus.bready = 0;
        checks++; if ({bus.bvalid, bus.awready, bus.wready} !== 3'b011) begin errors++; $display("FAIL w1_after_b: got %b exp 011", {bus.bvalid, bus.awready, bus.wready}); end
    endtask

    task automatic test_w_before_aw();
        bus.wdata = 32'h0BADF00D; bus.wstrb = 4'hF; bus.wvalid = 1;
        @(negedge clk);
        bus.wvalid = 0;
        checks++; if ({we, bus.wready, bus.awready} !== 3'b001) begin errors++; $display("FAIL w2_w_only: got %b exp 001", {we, bus.wready, bus.awready}); end
        @(negedge clk);
        checks++; if (we !== 1'b0) begin errors++; $display("FAIL w2_no_we: got %b exp 0", we); end
        bus.awaddr = 32'h80000004; bus.awvalid = 1;
        @(negedge clk);
        bus.awvalid = 0;
        checks++; if ({we, waddr, wdata} !== {1'b1, 32'h80000004, 32'h0BADF00D}) begin errors++; $display("FAIL w2_pair: got %b %h %h exp 1 80000004 0badf00d", we, waddr, wdata); end
        wdone = 1;
        @(negedge clk);
        wdone = 0; bus.bready = 1;
        checks++; if ({we, bus.bvalid, bus.bresp} !== 4'b0100) begin errors++; $display("FAIL w2_bresp: got %b exp 0100", {we, bus.bvalid, bus.bresp}); end
        @(negedge clk);
        bus.bready = 0;
    endtask

    task automatic test_partial_write();
        bus.awaddr = 32'h44; bus.awvalid = 1; bus.wdata = 32'h55; bus.wstrb = 4'h3; bus.wvalid = 1;
        @(negedge clk);
        bus.awvalid = 0; bus.wvalid = 0;
        checks++; if ({we, bus.bvalid, bus.bresp} !== 4'b0110) begin errors++; $display("FAIL w3_slverr: got %b exp 0110", {we, bus.bvalid, bus.bresp}); end
        bus.bready = 1;
        @(negedge clk);
        bus.bready = 0;
        checks++; if ({we, bus.bvalid} !== 2'b00) begin errors++; $display("FAIL w3_done: got %b exp 00", {we, bus.bvalid}); end
    endtask

    task automatic test_concurrent_rw();
        bus.araddr = 32'h8; bus.arvalid = 1;
        bus.awaddr = 32'h20; bus.awvalid = 1; bus.wdata = 32'hCAFEF00D; bus.wstrb = 4'hF; bus.wvalid = 1;
        @(negedge clk);
        bus.arvalid = 0; bus.awvalid = 0; bus.wvalid = 0;
        checks++; if ({re, raddr, we, waddr} !== {1'b1, 32'h8, 1'b1, 32'h20}) begin errors++; $display("FAIL rw_both_req: got %b %h %b %h exp 1 8 1 20", re, raddr, we, waddr); end
        wdone = 1;
        @(negedge clk);
        wdone = 0; bus.bready = 1;
        checks++; if ({re, bus.bvalid, bus.bresp} !== 4'b1100) begin errors++; $display("FAIL rw_write_b: got %b exp 1100", {re, bus.bvalid, bus.bresp}); end
        @(negedge clk);
        bus.bready = 0;
        checks++; if ({re, bus.bvalid} !== 2'b10) begin errors++; $display("FAIL rw_re_held: got %b exp 10", {re, bus.bvalid}); end
        @(negedge clk);
        rdone = 1; rdata = 32'h12345678;
        @(negedge clk);
        rdone = 0; rdata = 32'hFFFFFFFF; bus.rready = 1;
        checks++; if ({re, bus.rvalid, bus.rresp, bus.rdata} !== {4'b0100, 32'h12345678}) begin errors++; $display("FAIL rw_read_r: got %b %h exp 0100 12345678", {re, bus.rvalid, bus.rresp}, bus.rdata); end
        @(negedge clk);
        bus.rready = 0;
        checks++; if ({bus.rvalid, bus.arready} !== 2'b01) begin errors++; $display("FAIL rw_read_idle: got %b exp 01", {bus.rvalid, bus.arready}); end
    endtask

    task automatic test_timeout();
        int n;
        bus.awaddr = 32'h30; bus.awvalid = 1; bus.wdata = 32'h1; bus.wstrb = 4'hF; bus.wvalid = 1;
        @(negedge clk);
        bus.awvalid = 0; bus.wvalid = 0;
        n = 0;
        for (int i = 0; i < 20 && we; i++) begin n++; @(negedge clk); end
        checks++; if (n !== 8) begin errors++; $display("FAIL to_we_cycles: got %0d exp 8", n); end
        checks++; if ({we, bus.bvalid, bus.bresp} !== 4'b0110) begin errors++; $display("FAIL to_bresp: got %b exp 0110", {we, bus.bvalid, bus.bresp}); end
        bus.bready = 1; @(negedge clk); bus.bready = 0;
        bus.araddr = 32'hC; bus.arvalid = 1;
        @(negedge clk);
        bus.arvalid = 0;
        n = 0;
        for (int i = 0; i < 20 && re; i++) begin
            n++;
            if (n == 8) begin rdone = 1; rdata = 32'hA5A50001; end
            @(negedge clk);
        end
        rdone = 0;
        checks++; if (n !== 8) begin errors++; $display("FAIL to_re_cycles: got %0d exp 8", n); end
        checks++; if ({bus.rvalid, bus.rresp, bus.rdata} !== {3'b100, 32'hA5A50001}) begin errors++; $display("FAIL to_done_wins: got %b %h exp 100 a5a50001", {bus.rvalid, bus.rresp}, bus.rdata); end
        bus.rready = 1; @(negedge clk); bus.rready = 0;
        bus.araddr = 32'hC; bus.arvalid = 1;
        @(negedge clk);
        bus.arvalid = 0;
        for (int i = 0; i < 20 && re; i++) @(negedge clk);
        checks++; if ({bus.rvalid, bus.rresp, bus.rdata} !== {3'b110, 32'h0}) begin errors++; $display("FAIL to_read_slverr: got %b %h exp 110 0", {bus.rvalid, bus.rresp}, bus.rdata); end
        bus.rready = 1; @(negedge clk); bus.rready = 0;
    endtask

    task automatic test_reset_mid_txn();
        bus.araddr = 32'h4; bus.arvalid = 1;
        bus.awaddr = 32'h50; bus.awvalid = 1; bus.wdata = 32'h77; bus.wstrb = 4'hF; bus.wvalid = 1;
        @(negedge clk);
        bus.arvalid = 0; bus.awvalid = 0; bus.wvalid = 0;
        checks++; if ({we, re} !== 2'b11) begin errors++; $display("FAIL rst_pre: got %b exp 11", {we, re}); end
        #2 rst_n = 0;
        #1;
        checks++; if ({we, re, bus.awready, bus.arready} !== 4'b0) begin errors++; $display("FAIL rst_async_drop: got %b exp 0000", {we, re, bus.awready, bus.arready}); end
        wdone = 1; rdone = 1;
        @(negedge clk);
        wdone = 0; rdone = 0;
        @(negedge clk);
        rst_n = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++; if ({bus.bvalid, bus.rvalid, we, re} !== 4'b0) begin errors++; $display("FAIL rst_no_resp%0d: got %b exp 0000", i, {bus.bvalid, bus.rvalid, we, re}); end
        end
        bus.awaddr = 32'h60; bus.awvalid = 1; bus.wdata = 32'h99; bus.wstrb = 4'hF; bus.wvalid = 1;
        @(negedge clk);
        bus.awvalid = 0; bus.wvalid = 0;
        checks++; if ({we, waddr, wdata} !== {1'b1, 32'h60, 32'h99}) begin errors++; $display("FAIL rst_fresh_we: got %b %h %h exp 1 60 99", we, waddr, wdata); end
        wdone = 1;
        @(negedge clk);
        wdone = 0; bus.bready = 1;
        checks++; if ({bus.bvalid, bus.bresp} !== 3'b100) begin errors++; $display("FAIL rst_fresh_b: got %b exp 100", {bus.bvalid, bus.bresp}); end
        @(negedge clk);
        bus.bready = 0;
    endtask

    initial begin
        test_reset();
        test_same_cycle_write();
        test_w_before_aw();
        test_partial_write();
        test_concurrent_rw();
        test_timeout();
        test_reset_mid_txn();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/axi_lite_slave_ctrl.md
Name: axi_lite_slave_ctrl

Overview:
- AXI4-Lite slave front-end that converts PS GP-port transactions into the single-beat we/waddr/wdata/wdone and re/raddr/rdata/rdone interface consumed by the address decoder.
- Runs independent write and read FSMs and holds each back-end request until that path's done strobe arrives.
- A per-path watchdog converts a missing done into SLVERR, so the PS bus never hangs.
- Sits between the Zynq M_AXI_GP0 interconnect and the address decoder.

Parameters:
- ADDR_W, 32, AXI and back-end address width.
- DATA_W, 32, data width. Fixed at 32; WSTRB width is DATA_W/8.
- TIMEOUT_CYC, 256, cycles a request may wait for done before an error response. Legal range 2..65535.

Ports:
- clk  in  1  single clock for all logic
- rst_n  in  1  asynchronous active-low reset
- s_axi_awaddr  in  ADDR_W  write address
- s_axi_awvalid  in  1  write address valid
- s_axi_awready  out  1  write address ready
- s_axi_wdata  in  DATA_W  write data
- s_axi_wstrb  in  DATA_W/8  write strobes
- s_axi_wvalid  in  1  write data valid
- s_axi_wready  out  1  write data ready
- s_axi_bresp  out  2  write response
- s_axi_bvalid  out  1  write response valid
- s_axi_bready  in  1  write response ready
- s_axi_araddr  in  ADDR_W  read address
- s_axi_arvalid  in  1  read address valid
- s_axi_arready  out  1  read address ready
- s_axi_rdata  out  DATA_W  read data
- s_axi_rresp  out  2  read response
- s_axi_rvalid  out  1  read data valid
- s_axi_rready  in  1  read data ready
- we  out  1  back-end write request, level held until done
- waddr  out  ADDR_W  back-end write address
- wdata  out  DATA_W  back-end write data
- wdone  in  1  back-end write complete
- re  out  1  back-end read request, level held until done
- raddr  out  ADDR_W  back-end read address
- rdata  in  DATA_W  back-end read data, valid when rdone=1
- rdone  in  1  back-end read complete

Behaviour:

Reset (rst_n=0, asynchronous):
- All outputs 0, FSMs in IDLE, captured flags cleared.
- Ready outputs stay 0 during reset and assert no earlier than the first clk edge after rst_n rises. An init flop provides this.
- Reset mid-transaction: we/re drop immediately, the pending transaction is discarded and no B/R response is issued.

Write FSM (W_IDLE, W_EXEC, W_RESP):
- W_IDLE: awready = ~aw_held, wready = ~w_held. AW and W are accepted independently in any order or the same cycle, and their address/data/strobe are latched.
- Leaving W_IDLE, when both are held:
  - If wstrb==4'hF: go to W_EXEC; we=1 with the latched waddr/wdata from the next cycle.
  - If wstrb is anything else (partial write unsupported): go directly to W_RESP with bresp=SLVERR; we is never asserted.
- W_EXEC: we, waddr, wdata are held stable. The timer counts from 0.
  - wdone=1: we=0 next cycle, bresp=OKAY, go to W_RESP.
  - Timer reaches TIMEOUT_CYC-1 with no done: bresp=SLVERR, go to W_RESP.
  - Done and timeout in the same cycle: done wins (OKAY).
- W_RESP: bvalid=1 with bresp held stable until bready. On the handshake go to W_IDLE and clear the held flags. awready/wready stay 0 from capture until return to IDLE.
- Latency: AW+W in cycle 0, we in cycle 1; wdone in cycle 1 gives bvalid in cycle 2.

Read FSM (R_IDLE, R_EXEC, R_RESP):
- R_IDLE: arready=1. On the AR handshake latch araddr and go to R_EXEC.
- R_EXEC: re=1, raddr held stable.
  - rdone=1: capture rdata into s_axi_rdata, rresp=OKAY, go to R_RESP.
  - Timeout: s_axi_rdata=0, rresp=SLVERR, go to R_RESP.
  - Done wins over timeout in the same cycle.
- R_RESP: rvalid, rdata, rresp held stable until rready, then go to R_IDLE.
- Latency: AR in cycle 0, re in cycle 1, rdone in cycle 1 gives rvalid in cycle 2.

General rules:
- Read and write paths are fully concurrent; no arbitration between them (the back-end has separate paths).
- Done strobes arriving outside EXEC are ignored.
- Timer width is $clog2(TIMEOUT_CYC). The timer clears on EXEC entry and never wraps.
- bresp/rresp encoding: OKAY=2'b00, SLVERR=2'b10.
- A single outstanding transaction per path. No pipelining: the next AW/W/AR is accepted only after the response handshake completes.

Decomposition:
- Package axi_lite_pkg:
  - resp constants RESP_OKAY and RESP_SLVERR.
  - enums wr_state_t and rd_state_t.
  - default TIMEOUT_CYC localparam.
- One sub-module: axi_txn_timer (clear, enable, expired output, parameter TIMEOUT_CYC), instantiated once per path.

Test Plan:
1. AW and W in the same cycle (addr 0x0000_0010, data 0xDEAD_BEEF, strb F), wdone one cycle after we rises -> we held 2 cycles with waddr=0x10 and wdata=0xDEADBEEF; bvalid with OKAY; with bready held low 3 cycles, bvalid stays high and awready stays 0.
2. W presented 2 cycles before AW (addr 0x8000_0004) -> W accepted first, no we until AW accepted, then we with the correct pair; B response OKAY.
3. Write with wstrb=4'h3 -> we never asserted; bresp=SLVERR in the cycle after both channels are captured.
4. AR 0x0000_0008, rdone with rdata=0x1234_5678 three cycles after re -> rvalid, rdata=0x12345678, OKAY; re deasserts after done. Run a concurrent write in the same window; both complete correctly.
5. TIMEOUT_CYC=8, wdone never asserted -> we high exactly 8 cycles, then bresp=SLVERR. Repeat with rdone arriving on the 8th cycle -> OKAY (done beats timeout).
6. Assert rst_n low while in W_EXEC and R_EXEC -> we/re fall with no clock edge; after release, no bvalid/rvalid; a fresh write then completes with OKAY.
